// File: rtl/dbus_wb_bridge.sv
// Data-bus Wishbone classic master. It runs one CPU load/store per bus cycle, stalls the pipeline until ack,
// holds read data while the pipeline is frozen elsewhere, and aborts cycles to slaves that never acknowledge.
module dbus_wb_bridge #(
  parameter int aw        = 32,
  parameter int dw        = 32,
  parameter int TO_CYCLES = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cpu_ce_i,
  input  logic          cpu_we_i,
  input  logic [aw-1:0] cpu_addr_i,
  input  logic [3:0]    cpu_sel_i,
  input  logic [dw-1:0] cpu_data_i,
  output logic [dw-1:0] cpu_data_o,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          stallreq_o,
  output logic          bus_err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  input  logic [dw-1:0] wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_stb_o,
  output logic          wb_cyc_o,
  input  logic          wb_ack_i
);

  localparam int CW = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  state_t        state_q;
  logic [aw-1:0] adr_q;
  logic [dw-1:0] dat_q;
  logic [dw-1:0] rbuf_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          cyc_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic in_busy;
  logic ack_ok;
  logic timeout;

  assign cnt_d = cnt_q + CW'(1);

  always_comb begin
    in_busy    = (state_q == BUSY);
    ack_ok     = in_busy && wb_ack_i && !flush_i;
    timeout    = in_busy && !wb_ack_i && !flush_i && (cnt_q == TO_LAST);
    stallreq_o = ((state_q == IDLE) && cpu_ce_i && !flush_i) ||
                 (in_busy && !wb_ack_i && !flush_i && !timeout);
    // Load data passes straight through on the ack cycle so the stage needs no extra stall.
    if (ack_ok && !we_q) begin
      cpu_data_o = wb_dat_i;
    end else if (state_q == WAIT_STALL) begin
      cpu_data_o = rbuf_q;
    end else begin
      cpu_data_o = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      rbuf_q  <= '0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A stale ack from a slave that stretches it past cyc is ignored here.
          if (cpu_ce_i && !flush_i) begin
            cyc_q   <= 1'b1;
            adr_q   <= cpu_addr_i;
            sel_q   <= cpu_sel_i;
            we_q    <= cpu_we_i;
            dat_q   <= cpu_we_i ? cpu_data_i : '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i || wb_ack_i || (cnt_q == TO_LAST)) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            state_q <= (!flush_i && stall_i) ? WAIT_STALL : IDLE;
            if (ack_ok && !we_q) begin
              rbuf_q <= wb_dat_i;
            end
            if (timeout) begin
              err_q  <= 1'b1;
              rbuf_q <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_STALL: begin
          if (flush_i || !stall_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign bus_err_o = err_q;

endmodule
